// File: rtl/punc_ctrl_hs.sv
// PUnC LC3 multi-cycle control FSM with req/ack memory handshake, timeout watchdog,
// run/step gating, illegal-opcode trap, sticky error and retired-instruction counter.
module punc_ctrl_hs #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_W        = 8,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      ir,
   input  logic             nzp_true,
   input  logic             mem_ack,
   input  logic             run,
   input  logic             step,
   output logic             ir_clr,
   output logic             ir_ld,
   output logic             pc_clr,
   output logic             pc_ld,
   output logic             pc_inc,
   output logic             nzp_clr,
   output logic             nzp_ld,
   output logic             prev_ld,
   output logic [1:0]       pc_sel,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [2:0]       mem_addr_sel,
   output logic             rf_w_wr,
   output logic             rf_w_addr_sel,
   output logic             rf_r0_rd,
   output logic             rf_r1_rd,
   output logic             rf_r0_addr_sel,
   output logic [1:0]       rf_w_data_sel,
   output logic [1:0]       alu_sel,
   output logic             alu_first_val,
   output logic             halted,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT, S_ERROR
   } state_t;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_JSR = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_RTI = 4'b1000;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_RES = 4'b1101;
   localparam logic [3:0] OP_LEA = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

   state_t          state, state_nxt;
   logic [TO_W-1:0] wait_cnt;
   logic [3:0]      opcode;
   logic            mem_phase, timeout, two_phase, phase_done, retire;
   logic            unused_ir;

   assign opcode    = ir[15:12];
   assign unused_ir = ^{ir[10:6], ir[4:0]};
   assign two_phase = opcode inside {OP_LDI, OP_STI, OP_JSR};

   // Which states are currently waiting on a memory handshake
   always_comb begin
      mem_phase = 1'b0;
      case (state)
         S_FETCH: mem_phase = 1'b1;
         S_EXEC:  mem_phase = opcode inside {OP_LD, OP_LDI, OP_LDR, OP_ST, OP_STI, OP_STR};
         S_EXEC2: mem_phase = opcode inside {OP_LDI, OP_STI};
         default: mem_phase = 1'b0;
      endcase
   end

   // Ack in the limit cycle beats the timeout
   assign timeout    = mem_phase && !mem_ack && (MEM_TIMEOUT != 0) && (wait_cnt == TO_LIMIT);
   assign phase_done = !mem_phase || mem_ack;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_INIT;
      else     state <= state_nxt;
   end

   // Watchdog: counts non-ack cycles of the current memory phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        wait_cnt <= '0;
      else if (mem_phase && !mem_ack) wait_cnt <= wait_cnt + TO_W'(1);
      else                            wait_cnt <= '0;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         S_INIT:   state_nxt = S_IDLE;
         S_IDLE:   if (run || step) state_nxt = S_FETCH;
         S_FETCH: begin
            if (mem_ack)      state_nxt = S_DECODE;
            else if (timeout) state_nxt = S_ERROR;
         end
         S_DECODE: state_nxt = (opcode == OP_RTI || opcode == OP_RES) ? S_ERROR : S_EXEC;
         S_EXEC: begin
            if (opcode == OP_HLT) state_nxt = S_HALT;
            else if (timeout)     state_nxt = S_ERROR;
            else if (phase_done) begin
               if (two_phase) state_nxt = S_EXEC2;
               else begin
                  retire    = 1'b1;
                  state_nxt = run ? S_FETCH : S_IDLE;
               end
            end
         end
         S_EXEC2: begin
            if (timeout) state_nxt = S_ERROR;
            else if (phase_done) begin
               retire    = 1'b1;
               state_nxt = run ? S_FETCH : S_IDLE;
            end
         end
         default: state_nxt = state;
      endcase
   end

   // Datapath strobes
   always_comb begin
      ir_clr = 1'b0; ir_ld = 1'b0; pc_clr = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0;
      nzp_clr = 1'b0; nzp_ld = 1'b0; prev_ld = 1'b0; pc_sel = 2'd0;
      mem_rd = 1'b0; mem_wr = 1'b0; mem_addr_sel = 3'd0;
      rf_w_wr = 1'b0; rf_w_addr_sel = 1'b0; rf_r0_rd = 1'b0; rf_r1_rd = 1'b0;
      rf_r0_addr_sel = 1'b0; rf_w_data_sel = 2'd0; alu_sel = 2'd0; alu_first_val = 1'b0;
      case (state)
         S_INIT: begin
            pc_clr = 1'b1; ir_clr = 1'b1; nzp_clr = 1'b1;
         end
         S_FETCH: begin
            mem_rd = 1'b1;
            ir_ld  = mem_ack;
            pc_inc = mem_ack;
         end
         S_EXEC: begin
            case (opcode)
               OP_ADD, OP_AND: begin
                  rf_r1_rd      = 1'b1;
                  rf_r0_rd      = !ir[5];
                  alu_sel       = (opcode == OP_AND) ? 2'd1 : 2'd0;
                  alu_first_val = ir[5];
                  rf_w_wr       = 1'b1;
                  nzp_ld        = 1'b1;
               end
               OP_NOT: begin
                  rf_r1_rd = 1'b1; alu_sel = 2'd2; rf_w_wr = 1'b1; nzp_ld = 1'b1;
               end
               OP_BR: begin
                  pc_ld = nzp_true; pc_sel = 2'd0;
               end
               OP_JMP: begin
                  rf_r1_rd = 1'b1; pc_sel = 2'd2; pc_ld = 1'b1;
               end
               OP_JSR: begin
                  rf_w_wr = 1'b1; rf_w_addr_sel = 1'b1; rf_w_data_sel = 2'd2;
               end
               OP_LD, OP_LDR: begin
                  rf_r1_rd      = (opcode == OP_LDR);
                  mem_rd        = 1'b1;
                  mem_addr_sel  = (opcode == OP_LDR) ? 3'd2 : 3'd1;
                  rf_w_wr       = mem_ack;
                  rf_w_data_sel = 2'd1;
                  nzp_ld        = mem_ack;
               end
               OP_LEA: begin
                  rf_w_wr = 1'b1; rf_w_data_sel = 2'd3; nzp_ld = 1'b1;
               end
               OP_ST, OP_STR: begin
                  rf_r1_rd       = (opcode == OP_STR);
                  rf_r0_rd       = 1'b1;
                  rf_r0_addr_sel = 1'b1;
                  mem_wr         = 1'b1;
                  mem_addr_sel   = (opcode == OP_STR) ? 3'd2 : 3'd1;
               end
               OP_LDI, OP_STI: begin
                  mem_rd       = 1'b1;
                  mem_addr_sel = 3'd1;
                  prev_ld      = mem_ack;
               end
               default: ;
            endcase
         end
         S_EXEC2: begin
            case (opcode)
               OP_JSR: begin
                  pc_ld    = 1'b1;
                  pc_sel   = ir[11] ? 2'd1 : 2'd2;
                  rf_r1_rd = !ir[11];
               end
               OP_LDI: begin
                  mem_rd        = 1'b1;
                  mem_addr_sel  = 3'd3;
                  rf_w_wr       = mem_ack;
                  rf_w_data_sel = 2'd1;
                  nzp_ld        = mem_ack;
               end
               OP_STI: begin
                  rf_r0_rd       = 1'b1;
                  rf_r0_addr_sel = 1'b1;
                  mem_wr         = 1'b1;
                  mem_addr_sel   = 3'd4;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Sticky status and retire counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halted      <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'd0;
         instr_count <= '0;
      end else begin
         if (retire) instr_count <= instr_count + CNT_W'(1);
         if (state_nxt == S_HALT) halted <= 1'b1;
         if (state_nxt == S_ERROR && state != S_ERROR) begin
            err      <= 1'b1;
            err_code <= (state == S_DECODE) ? 2'd2 : 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_punc_ctrl_hs.sv
// Scoreboard bench for punc_ctrl_hs: random programs against an opcode-level event model,
// plus directed timing, watchdog, step and trap scenarios.
module tb_punc_ctrl_hs;
   localparam int TO = 4;
   localparam logic [15:0] HLT_I = 16'hF025;

   logic clk = 1'b0, rst = 1'b1;
   logic [15:0] ir = '0;
   logic nzp_true = 1'b0, mem_ack = 1'b0, run = 1'b0, step = 1'b0;
   logic ir_clr, ir_ld, pc_clr, pc_ld, pc_inc, nzp_clr, nzp_ld, prev_ld;
   logic [1:0] pc_sel, rf_w_data_sel, alu_sel, err_code;
   logic mem_rd, mem_wr, rf_w_wr, rf_w_addr_sel, rf_r0_rd, rf_r1_rd, rf_r0_addr_sel;
   logic [2:0] mem_addr_sel;
   logic alu_first_val, halted, err;
   logic [15:0] instr_count;

   punc_ctrl_hs #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ir(ir), .nzp_true(nzp_true), .mem_ack(mem_ack),
      .run(run), .step(step), .ir_clr(ir_clr), .ir_ld(ir_ld), .pc_clr(pc_clr),
      .pc_ld(pc_ld), .pc_inc(pc_inc), .nzp_clr(nzp_clr), .nzp_ld(nzp_ld),
      .prev_ld(prev_ld), .pc_sel(pc_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr_sel(mem_addr_sel), .rf_w_wr(rf_w_wr), .rf_w_addr_sel(rf_w_addr_sel),
      .rf_r0_rd(rf_r0_rd), .rf_r1_rd(rf_r1_rd), .rf_r0_addr_sel(rf_r0_addr_sel),
      .rf_w_data_sel(rf_w_data_sel), .alu_sel(alu_sel), .alu_first_val(alu_first_val),
      .halted(halted), .err(err), .err_code(err_code), .instr_count(instr_count));

   always #5 clk = ~clk;

   typedef struct packed {
      logic rd, wr; logic [2:0] asel; logic irl, pinc, pld; logic [1:0] psel;
      logic wwr, wasel; logic [1:0] wdsel; logic nld, prl; logic [1:0] alu; logic afv;
   } ev_t;

   int checks = 0, errors = 0;
   int lat_fix = 0;
   int n_ir_ld = 0;
   logic sb_on = 1'b0;
   logic [15:0] prog[$];
   ev_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Fields that only matter when the owning strobe is active are zeroed
   function automatic ev_t mask(input ev_t e);
      ev_t m = e;
      if (!(m.rd || m.wr)) m.asel = '0;
      if (!m.pld) m.psel = '0;
      if (!m.wwr) begin m.wasel = 1'b0; m.wdsel = '0; end
      if (!(m.wwr && m.wdsel == 2'd0)) begin m.alu = '0; m.afv = 1'b0; end
      return m;
   endfunction

   function automatic void push(input ev_t e);
      exp_q.push_back(mask(e));
   endfunction

   function automatic void push_fetch();
      ev_t e = '0;
      e.rd = 1'b1; e.irl = 1'b1; e.pinc = 1'b1;
      push(e);
   endfunction

   // Reference model: visible datapath events per LC3 opcode
   function automatic void push_exec(input logic [15:0] i, input logic nz);
      ev_t e = '0;
      logic [3:0] op = i[15:12];
      case (op)
         4'h1, 4'h5, 4'h9: begin
            e.wwr = 1'b1; e.nld = 1'b1;
            if (op == 4'h5) e.alu = 2'd1; else if (op == 4'h9) e.alu = 2'd2;
            e.afv = (op != 4'h9) && i[5];
            push(e);
         end
         4'h0: if (nz) begin e.pld = 1'b1; push(e); end
         4'hC: begin e.pld = 1'b1; e.psel = 2'd2; push(e); end
         4'h4: begin
            e.wwr = 1'b1; e.wasel = 1'b1; e.wdsel = 2'd2; push(e);
            e = '0; e.pld = 1'b1; e.psel = i[11] ? 2'd1 : 2'd2; push(e);
         end
         4'h2, 4'h6: begin
            e.rd = 1'b1; e.asel = (op == 4'h2) ? 3'd1 : 3'd2;
            e.wwr = 1'b1; e.wdsel = 2'd1; e.nld = 1'b1; push(e);
         end
         4'hE: begin e.wwr = 1'b1; e.wdsel = 2'd3; e.nld = 1'b1; push(e); end
         4'h3, 4'h7: begin e.wr = 1'b1; e.asel = (op == 4'h3) ? 3'd1 : 3'd2; push(e); end
         4'hA: begin
            e.rd = 1'b1; e.asel = 3'd1; e.prl = 1'b1; push(e);
            e = '0; e.rd = 1'b1; e.asel = 3'd3; e.wwr = 1'b1; e.wdsel = 2'd1; e.nld = 1'b1; push(e);
         end
         4'hB: begin
            e.rd = 1'b1; e.asel = 3'd1; e.prl = 1'b1; push(e);
            e = '0; e.wr = 1'b1; e.asel = 3'd4; push(e);
         end
         default: ;
      endcase
   endfunction

   // Environment: instruction register, nzp condition and variable-latency memory
   initial begin : env
      int wl = -1;
      logic s_ir_ld;
      logic [15:0] nxt;
      forever begin
         @(negedge clk);
         s_ir_ld = ir_ld;
         @(posedge clk);
         #1;
         if (rst) begin
            mem_ack = 1'b0; wl = -1;
         end else begin
            if (s_ir_ld) begin
               nxt = (prog.size() > 0) ? prog.pop_front() : HLT_I;
               ir = nxt;
               nzp_true = 1'($urandom_range(0, 1));
               if (sb_on) begin
                  push_exec(nxt, nzp_true);
                  if (nxt[15:12] != 4'hF) push_fetch();
               end
            end
            if (mem_rd || mem_wr) begin
               if (wl < 0) wl = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
               mem_ack = (wl == 0);
               wl = (wl == 0) ? -1 : wl - 1;
            end else begin
               mem_ack = 1'b0; wl = -1;
            end
         end
      end
   end

   // Monitor: pops the expected event whenever the DUT shows a visible action
   initial begin : monitor
      ev_t a, e;
      forever begin
         @(negedge clk);
         if (ir_ld) n_ir_ld++;
         if (sb_on && !rst && (ir_ld || pc_ld || rf_w_wr || nzp_ld || prev_ld ||
                               ((mem_rd || mem_wr) && mem_ack))) begin
            a = '0;
            a.rd = mem_rd; a.wr = mem_wr; a.asel = mem_addr_sel; a.irl = ir_ld;
            a.pinc = pc_inc; a.pld = pc_ld; a.psel = pc_sel; a.wwr = rf_w_wr;
            a.wasel = rf_w_addr_sel; a.wdsel = rf_w_data_sel; a.nld = nzp_ld;
            a.prl = prev_ld; a.alu = alu_sel; a.afv = alu_first_val;
            a = mask(a);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra_event: got %h expected none (ir=%h)", a, ir);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  errors++;
                  $display("FAIL sb_event: got %h expected %h (ir=%h)", a, e, ir);
               end
            end
         end
      end
   end

   initial begin : guard
      #300000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   // Leaves the bench 1ns into cycle 0, where the DUT sits in INIT
   task automatic do_reset();
      rst = 1'b1; run = 1'b0; step = 1'b0; sb_on = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      n_ir_ld = 0;
   endtask

   task automatic wait_halt_or_err(input int n);
      for (int k = 0; k < n && !halted && !err; k++) @(negedge clk);
   endtask

   initial begin : main
      int ir_cyc, wr_cyc, nack, run_len, wr_cnt, rd_cnt;
      logic started, wr_ok, pl;
      int lens[3];
      logic [2:0] asels[3];
      logic [15:0] ins;
      logic [3:0] legal[13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                4'h9, 4'hA, 4'hB, 4'hC, 4'hE};

      // Reset values
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_halted", halted, 0); chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0); chk("rst_count", instr_count, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_init_strobes", {pc_clr, ir_clr, nzp_clr, ir_ld, rf_w_wr}, 5'b11100);

      // ADD R1,R1,#5 with zero-wait memory
      prog.delete(); prog.push_back(16'h1265); lat_fix = 0;
      do_reset(); run = 1'b1;
      ir_cyc = -1; wr_cyc = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ir_ld && ir_cyc < 0) ir_cyc = k;
         if (rf_w_wr && wr_cyc < 0) begin
            wr_cyc = k;
            chk("add_nzp_ld", nzp_ld, 1); chk("add_imm", alu_first_val, 1);
            chk("add_alu_sel", alu_sel, 0);
         end
      end
      chk("add_ir_ld_cycle", ir_cyc, 2); chk("add_wr_cycle", wr_cyc, 4);
      chk("add_count", instr_count, 1);

      // LDI with 3-cycle ack delay on every access
      prog.delete(); prog.push_back(16'hA405); lat_fix = 3;
      do_reset(); run = 1'b1;
      started = 1'b0; nack = 0; run_len = 0; wr_cnt = 0; wr_ok = 1'b0; pl = 1'b0;
      lens = '{0, 0, 0}; asels = '{3'd7, 3'd7, 3'd7};
      for (int k = 0; k < 60 && nack < 3; k++) begin
         @(negedge clk);
         if (started) begin
            if (rf_w_wr) begin wr_cnt++; if (mem_ack && nack == 1) wr_ok = 1'b1; end
            if (mem_rd) begin
               run_len++;
               if (mem_ack) begin
                  lens[nack] = run_len; asels[nack] = mem_addr_sel;
                  if (nack == 0) pl = prev_ld;
                  nack++; run_len = 0;
               end
            end
         end
         if (ir_ld) started = 1'b1;
      end
      chk("ldi_phase1_len", lens[0], 4); chk("ldi_phase2_len", lens[1], 4);
      chk("ldi_asel1", asels[0], 1); chk("ldi_asel2", asels[1], 3);
      chk("ldi_prev_ld", pl, 1); chk("ldi_wr_pulses", wr_cnt, 1);
      chk("ldi_wr_in_ack2", wr_ok, 1);

      // Reset mid-fetch drops the request at once
      prog.delete(); lat_fix = 1000;
      do_reset(); run = 1'b1;
      repeat (3) @(negedge clk);
      chk("fetch_before_rst", mem_rd, 1);
      #2 rst = 1'b1;
      #1 chk("rst_drops_rd", mem_rd, 0);

      // Watchdog expiry in FETCH
      do_reset(); run = 1'b1; rd_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (mem_rd) rd_cnt++;
      end
      chk("to_rd_cycles", rd_cnt, TO + 1); chk("to_err", err, 1);
      chk("to_err_code", err_code, 1); chk("to_rd_after", mem_rd, 0);

      // Ack exactly on the timeout cycle completes the access
      prog.delete(); prog.push_back(16'h1042); lat_fix = TO;
      do_reset(); run = 1'b1;
      wait_halt_or_err(80);
      chk("to_edge_err", err, 0); chk("to_edge_halted", halted, 1);
      chk("to_edge_count", instr_count, 1);

      // Single step with 5 queued instructions; a step during DECODE is ignored
      prog.delete();
      for (int k = 0; k < 5; k++) prog.push_back(16'h1021);
      lat_fix = 0;
      do_reset(); run = 1'b0;
      repeat (3) @(posedge clk);
      #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      repeat (40) @(negedge clk);
      chk("step_fetches", n_ir_ld, 1); chk("step_count", instr_count, 1);
      chk("step_idle_rd", mem_rd, 0); chk("step_halted", halted, 0);

      // Illegal opcodes trap with err_code 2
      for (int t = 0; t < 2; t++) begin
         prog.delete(); prog.push_back(t == 0 ? 16'hD123 : 16'h8000); lat_fix = -1;
         do_reset(); run = 1'b1;
         wait_halt_or_err(60);
         repeat (3) @(negedge clk);
         chk("ill_err", err, 1); chk("ill_err_code", err_code, 2);
         chk("ill_count", instr_count, 0); chk("ill_halted", halted, 0);
      end

      // HLT: sticky halt, no retire, cleared only by reset
      prog.delete(); prog.push_back(16'h1261); prog.push_back(16'h5263); lat_fix = -1;
      do_reset(); run = 1'b1;
      wait_halt_or_err(80);
      repeat (5) @(negedge clk);
      chk("hlt_halted", halted, 1); chk("hlt_count", instr_count, 2);
      chk("hlt_err", err, 0); chk("hlt_quiet", {mem_rd, ir_ld}, 0);
      rst = 1'b1;
      #1 chk("hlt_rst_init", pc_clr, 1); chk("hlt_rst_halted", halted, 0);
      chk("hlt_rst_count", instr_count, 0);

      // Random program against the scoreboard
      prog.delete();
      for (int k = 0; k < 40; k++) begin
         ins = 16'($urandom);
         ins[15:12] = legal[$urandom_range(0, 12)];
         prog.push_back(ins);
      end
      lat_fix = -1;
      do_reset();
      exp_q.delete(); push_fetch(); sb_on = 1'b1; run = 1'b1;
      wait_halt_or_err(4000);
      repeat (3) @(negedge clk);
      chk("rnd_halted", halted, 1); chk("rnd_err", err, 0);
      chk("rnd_count", instr_count, 40); chk("rnd_sb_drained", exp_q.size(), 0);
      sb_on = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
